// File: rtl/serial_sub_ctrl_if.sv
// Handshake and operand/result bundle for serial_sub_ctrl.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow flag (ovf).
interface serial_sub_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one full-subtractor cell stepped LSB first over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             cell_diff, cell_bout, last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign cell_diff = a_sr_q[0] ^ b_sr_q[0] ^ bin_q;
    assign cell_bout = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & bin_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {cell_diff, res_q[WIDTH-1:1]};
                bin_d  = cell_bout;
                if (last_bit) begin
                    state_d  = StDone;
                    diff_d   = res_d;
                    borrow_d = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last step a_sr/b_sr bit 0 hold the captured operand MSBs.
                    ovf_d    = (a_sr_q[0] != b_sr_q[0]) && (cell_diff != a_sr_q[0]);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy       = (state_q == StRun);
    assign bus.done       = (state_q == StDone);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed plan scenarios plus randomized operands
// checked against an arithmetic reference model.
module tb_serial_sub_ctrl;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_sub_ctrl_if #(.WIDTH(W)) sif ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint r;
        r = (longint'(av) - longint'(bv)) % (longint'(1) << W);
        if (r < 0) r = r + (longint'(1) << W);
        return r[W-1:0];
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] av, input logic [W-1:0] bv);
        return (int'(av) < int'(bv));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int sa, sb, r;
        sa = $signed(av);
        sb = $signed(bv);
        r  = sa - sb;
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    // Runs one operation from IDLE; returns at the negedge inside the done cycle.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat,
                         output int busy_cnt, output logic timed_out, output logic moved);
        logic [W-1:0] prev;
        @(negedge clk);
        prev      = sif.diff;
        sif.a     = av;
        sif.b     = bv;
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        sif.a     = W'($urandom);
        sif.b     = W'($urandom);
        lat       = 0;
        busy_cnt  = 0;
        timed_out = 1'b1;
        moved     = 1'b0;
        for (int i = 1; i <= 4 * W; i++) begin
            @(negedge clk);
            if (sif.done) begin
                lat       = i;
                timed_out = 1'b0;
                break;
            end
            if (sif.busy) busy_cnt++;
            if (sif.diff !== prev) moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sif.busy, sif.done, sif.borrow_out} !== 3'b000 || sif.diff !== '0) begin
            errors++;
            $display("FAIL reset_state: busy/done/borrow=%b diff=%0h required 000/0",
                     {sif.busy, sif.done, sif.borrow_out}, sif.diff);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (sif.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b required 0", sif.ovf);
        end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: busy=%b done=%b required 0/0", sif.busy, sif.done);
            end
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic to, mv;
        do_op(8'd100, 8'd37, lat, bc, to, mv);
        checks++;
        if (to || lat != W + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d (timeout=%b) required %0d", lat, to, W + 1);
        end
        checks++;
        if (bc != W) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d required %0d", bc, W);
        end
        checks++;
        if (sif.diff !== 8'd63 || sif.borrow_out !== 1'b0 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: diff=%0d borrow=%b busy=%b required 63/0/0",
                     sif.diff, sif.borrow_out, sif.busy);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (sif.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf: got %b required 0", sif.ovf);
        end
`endif
        @(negedge clk);
        checks++;
        if (sif.done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got %b required 0", sif.done);
        end
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        sif.start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (sif.diff !== 8'd63 || sif.done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d cycles deviated, required diff=63 done=0 for all", bad);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] av[3]  = '{8'd5, 8'd0, 8'd255};
        logic [W-1:0] bv[3]  = '{8'd9, 8'd1, 8'd255};
        logic [W-1:0] exd[3] = '{8'hFC, 8'hFF, 8'h00};
        logic         exb[3] = '{1'b1, 1'b1, 1'b0};
        int lat, bc;
        logic to, mv;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], lat, bc, to, mv);
            checks++;
            if (to || sif.diff !== exd[i] || sif.borrow_out !== exb[i]) begin
                errors++;
                $display("FAIL directed_%0d: diff=%0h borrow=%b timeout=%b required %0h/%b",
                         i, sif.diff, sif.borrow_out, to, exd[i], exb[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones, first;
        @(negedge clk);
        sif.a = 8'd200; sif.b = 8'd50; sif.start = 1'b1;
        @(posedge clk);
        #1 sif.start = 1'b0;
        repeat (3) @(negedge clk);
        sif.a = 8'd1; sif.b = 8'd1; sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        dones = 0;
        first = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (sif.done) begin
                dones++;
                if (dones == 1) begin
                    first = 1;
                    checks++;
                    if (sif.diff !== 8'd150 || sif.borrow_out !== 1'b0) begin
                        errors++;
                        $display("FAIL ignored_start_result: diff=%0d borrow=%b required 150/0",
                                 sif.diff, sif.borrow_out);
                    end
                end
            end
        end
        checks++;
        if (dones != 1 || first != 1) begin
            errors++;
            $display("FAIL ignored_start_dones: got %0d done pulses required 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bc;
        logic to, mv;
        @(negedge clk);
        sif.a = 8'd77; sif.b = 8'd7; sif.start = 1'b1;
        @(posedge clk);
        #1 sif.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before_reset: got %b required 1", sif.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sif.busy !== 1'b0 || sif.diff !== '0 || sif.borrow_out !== 1'b0 || sif.done !== 1'b0)
        begin
            errors++;
            $display("FAIL mid_reset_async: busy=%b diff=%0h borrow=%b done=%b required 0/0/0/0",
                     sif.busy, sif.diff, sif.borrow_out, sif.done);
        end
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (sif.done) dones++;
        end
        rst = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            if (sif.done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d done pulses required 0", dones);
        end
        do_op(8'd77, 8'd7, lat, bc, to, mv);
        checks++;
        if (to || sif.diff !== 8'd70 || sif.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: diff=%0d borrow=%b timeout=%b required 70/0",
                     sif.diff, sif.borrow_out, to);
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        int lat, bc;
        logic to, mv;
        do_op(8'h80, 8'h01, lat, bc, to, mv);
        checks++;
        if (to || sif.diff !== 8'h7F || sif.ovf !== 1'b1 || sif.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL ovf_80_01: diff=%0h ovf=%b borrow=%b required 7f/1/0",
                     sif.diff, sif.ovf, sif.borrow_out);
        end
        do_op(8'h7F, 8'hFF, lat, bc, to, mv);
        checks++;
        if (to || sif.diff !== 8'h80 || sif.ovf !== 1'b1 || sif.borrow_out !== 1'b1) begin
            errors++;
            $display("FAIL ovf_7f_ff: diff=%0h ovf=%b borrow=%b required 80/1/1",
                     sif.diff, sif.ovf, sif.borrow_out);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] av[5], bv[5];
        int cnt;
        logic seen;
        for (int i = 0; i < 5; i++) begin
            av[i] = W'($urandom);
            bv[i] = W'($urandom);
        end
        @(negedge clk);
        sif.a = av[0]; sif.b = bv[0]; sif.start = 1'b1;
        @(posedge clk);
        #1;
        for (int op = 0; op < 5; op++) begin
            cnt  = 0;
            seen = 1'b0;
            for (int i = 1; i <= 4 * W; i++) begin
                @(negedge clk);
                if (sif.done) begin
                    cnt  = i;
                    seen = 1'b1;
                    break;
                end
            end
            checks++;
            if (!seen || cnt != ((op == 0) ? W + 1 : W + 2)) begin
                errors++;
                $display("FAIL b2b_interval_%0d: got %0d required %0d", op, cnt,
                         (op == 0) ? W + 1 : W + 2);
            end
            checks++;
            if (sif.diff !== ref_diff(av[op], bv[op]) ||
                sif.borrow_out !== ref_borrow(av[op], bv[op])) begin
                errors++;
                $display("FAIL b2b_result_%0d: diff=%0h borrow=%b required %0h/%b", op, sif.diff,
                         sif.borrow_out, ref_diff(av[op], bv[op]), ref_borrow(av[op], bv[op]));
            end
            if (op < 4) begin
                sif.a = av[op+1];
                sif.b = bv[op+1];
            end else begin
                sif.start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return W'(1) << (W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [W-1:0] av, bv;
        int lat, bc;
        logic to, mv;
        for (int n = 0; n < 40; n++) begin
            av = pick_val();
            bv = pick_val();
            do_op(av, bv, lat, bc, to, mv);
            checks++;
            if (to || lat != W + 1 || mv) begin
                errors++;
                $display("FAIL rand_timing_%0d: lat=%0d timeout=%b diff_moved=%b required %0d/0/0",
                         n, lat, to, mv, W + 1);
            end
            checks++;
            if (sif.diff !== ref_diff(av, bv) || sif.borrow_out !== ref_borrow(av, bv)) begin
                errors++;
                $display("FAIL rand_result_%0d: a=%0h b=%0h diff=%0h borrow=%b required %0h/%b",
                         n, av, bv, sif.diff, sif.borrow_out, ref_diff(av, bv), ref_borrow(av, bv));
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (sif.ovf !== ref_ovf(av, bv)) begin
                errors++;
                $display("FAIL rand_ovf_%0d: a=%0h b=%0h got %b required %b",
                         n, av, bv, sif.ovf, ref_ovf(av, bv));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_directed();
        test_start_ignored();
        test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
